alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Controller that sequences the UART-fed ALU datapath.
- Collects the 3-byte command (operand A, operand B, opcode) from the receive path.
- Drives the ALU operand and opcode lines, captures the result, and launches exactly one transmit per command.
- Sits between rx_module, ALU and tx_module. It replaces the separate rx/tx interface glue with a single FSM that also validates opcodes and reports errors.

Parameters:
- DBIT, 8, data byte width; also the ALU operand width.
- OPW, 6, ALU opcode width (low OPW bits of the opcode byte).
- TIMEOUT_CYC, 1_000_000, inter-byte timeout in clk cycles (used only with the feature below).
- ERR_CODE, 8'hEE, byte transmitted in place of a result for an invalid command.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  DBIT  received byte.
- tx_done_tick  in  1  one-cycle pulse: transmitter finished its byte.
- alu_result  in  DBIT  combinational ALU output.
- alu_a  out  DBIT  signed operand A (registered).
- alu_b  out  DBIT  signed operand B (registered).
- alu_op  out  OPW  ALU opcode (registered).
- tx_start  out  1  one-cycle pulse that launches a transmit.
- tx_data  out  DBIT  byte to transmit; stable from tx_start until tx_done_tick.
- busy  out  1  high in every state except IDLE.
- err_tick  out  1  one-cycle pulse on a detected error.

Behaviour:
- Reset: state=IDLE. alu_a, alu_b, alu_op, tx_data = 0. tx_start, err_tick, busy = 0. Reset is honoured in any state; a partial command is discarded and an in-flight tx is not waited for.
- States: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- IDLE: on rx_done_tick, alu_a<=rx_data, go to GET_B.
- GET_B: on rx_done_tick, alu_b<=rx_data, go to GET_OP.
- GET_OP: on rx_done_tick, validate the byte. It is valid iff bits[DBIT-1:OPW]==0 and bits[OPW-1:0] is in the package opcode list.
  - Valid: alu_op<=rx_data[OPW-1:0], valid flag<=1.
  - Invalid: alu_op unchanged, valid flag<=0.
  - Either case: go to EXEC.
- EXEC: exactly one cycle, giving the ALU one settle cycle.
  - tx_data<= valid ? alu_result : ERR_CODE.
  - If invalid, pulse err_tick this cycle.
  - Go to SEND.
- SEND: tx_start=1 for exactly this cycle, go to WAIT_TX.
- WAIT_TX: hold tx_data; on tx_done_tick go to IDLE.
- Latency: the opcode byte's rx_done_tick at cycle n gives EXEC at n+1 and tx_start high at n+2.
- alu_a/alu_b/alu_op hold their values after the command, until overwritten by the next command.
- rx_done_tick in EXEC, SEND or WAIT_TX: byte dropped, err_tick pulsed (overrun). State is unaffected.
- tx_done_tick outside WAIT_TX: ignored.
- tx_start never asserts outside SEND; at most one tx_start per command.
- If an overrun coincides with an EXEC invalid-opcode error, err_tick is a single pulse (OR of both).

Optional Feature:
- Macro: ALU_CMD_TIMEOUT_EN.
- Defined:
  - A counter resets on every rx_done_tick and on entry to GET_B.
  - In GET_B/GET_OP, reaching TIMEOUT_CYC-1 without a byte forces IDLE and pulses err_tick; the partial command is discarded and nothing is transmitted.
  - If rx_done_tick arrives in the expiry cycle, the byte wins and no timeout occurs.
  - Counter width = $clog2(TIMEOUT_CYC).
- Undefined: no counter; GET_B/GET_OP wait indefinitely.

Decomposition:
- Package alu_uart_pkg holds:
  - state enum.
  - Opcode constants: OP_ADD 6'b100000, OP_SUB 6'b100010, OP_AND 6'b100100, OP_OR 6'b100101, OP_XOR 6'b100110, OP_NOR 6'b100111, OP_SRA 6'b000011, OP_SRL 6'b000010.
  - function is_valid_op.
  - default ERR_CODE.
- No sub-module is needed; the timeout counter stays inline under the macro.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD), with the ALU model connected: tx_start one pulse exactly 2 cycles after the 3rd rx_done_tick, tx_data=0x08, busy drops after tx_done_tick.
- Bytes 0x03, 0x05, 0x22 (SUB): tx_data=0xFE. Then 0xF0, 0x02, 0x03 (SRA): tx_data=0xFC. alu_a/alu_b hold the last operands.
- Bytes 0x01, 0x02, 0x3F, then separately 0x01, 0x02, 0x60 (upper bits set): each transmits 0xEE with one err_tick in EXEC; alu_op unchanged from the prior command.
- Full command, then a 4th rx_done_tick (0xAA) during WAIT_TX: err_tick pulse, only one tx_start, next command 0x02, 0x02, 0x24 yields 0x02.
- With ALU_CMD_TIMEOUT_EN and TIMEOUT_CYC=16: send 0x05, wait 20 cycles → IDLE plus err_tick, no tx_start. Then 0x01, 0x01, 0x20 transmits 0x02.
- Assert reset in GET_OP and again in WAIT_TX: all outputs 0, state IDLE immediately (async); no tx_start follows.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART-fed ALU command path:
// sequencer states, the legal ALU opcodes and the error reply byte.
package alu_uart_pkg;

    localparam int OPCODE_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
    localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;

    localparam logic [7:0] ERR_CODE_DEFAULT = 8'hEE;

    function automatic logic is_valid_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
            default:                        is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Collects A, B and opcode bytes from the UART receiver, runs the ALU and sends one reply byte.
// Optional inter-byte timeout is enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_sequencer
    import alu_uart_pkg::*;
#(
    parameter int              DBIT        = 8,
    parameter int              OPW         = 6,
    parameter int              TIMEOUT_CYC = 1_000_000,
    parameter logic [DBIT-1:0] ERR_CODE    = DBIT'(ERR_CODE_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_data,
    input  logic            tx_done_tick,
    input  logic [DBIT-1:0] alu_result,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    output logic            busy,
    output logic            err_tick
);

    state_t state, state_next;
    logic   valid_q;
    logic   op_ok;
    logic   timeout_hit;
    logic   collecting;

    assign op_ok = (rx_data[DBIT-1:OPW] == '0) &&
                   is_valid_op(OPCODE_W'(rx_data[OPW-1:0]));
    assign collecting = (state == GET_B) || (state == GET_OP);

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] wait_cnt;

    // Counter only runs while a partial command is pending; any byte restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (rx_done_tick || !collecting) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout_hit = collecting && !rx_done_tick &&
                         (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        err_tick   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (rx_done_tick) state_next = GET_B;
            GET_B: begin
                if (rx_done_tick)     state_next = GET_OP;
                else if (timeout_hit) state_next = IDLE;
            end
            GET_OP: begin
                if (rx_done_tick)     state_next = EXEC;
                else if (timeout_hit) state_next = IDLE;
            end
            EXEC: begin
                err_tick   = !valid_q;
                state_next = SEND;
            end
            SEND: begin
                tx_start   = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: if (tx_done_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Bytes arriving while a reply is in flight are overruns and get dropped.
        if (rx_done_tick && (state == EXEC || state == SEND || state == WAIT_TX))
            err_tick = 1'b1;
        if (timeout_hit)
            err_tick = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            valid_q <= 1'b0;
            tx_data <= '0;
        end else begin
            state <= state_next;
            if (rx_done_tick && state == IDLE)
                alu_a <= rx_data;
            if (rx_done_tick && state == GET_B)
                alu_b <= rx_data;
            if (rx_done_tick && state == GET_OP) begin
                valid_q <= op_ok;
                if (op_ok)
                    alu_op <= rx_data[OPW-1:0];
            end
            // The ALU has had a full cycle to settle on the new operands by now.
            if (state == EXEC)
                tx_data <= valid_q ? alu_result : ERR_CODE;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed commands plus random traffic,
// compared every cycle against a command-level reference model.
module tb_alu_cmd_sequencer;

    localparam int TCYC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, err_tick;

    int checks = 0;
    int errors = 0;
    int tx_start_cnt = 0;
    int err_cnt = 0;

    logic [7:0] legal_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.TIMEOUT_CYC(TCYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .tx_done_tick (tx_done_tick),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .err_tick     (err_tick)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [7:0] r;
        case (op)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h27:   r = ~(a | b);
            6'h03:   r = $signed(a) >>> b;
            6'h02:   r = a >> b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic op_legal(input logic [7:0] v);
        return v inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: bytes collected, last operands, and age of the in-flight reply.
    int         m_n = 0;
    bit         m_inflight = 0;
    int         m_age = 0;
    bit         m_valid = 0;
    int         m_wait = 0;
    logic [7:0] m_a = 0, m_b = 0, m_txd = 0;
    logic [5:0] m_op = 0;

    always @(negedge clk) begin : compare
        logic e_busy, e_start, e_err, timeout_now;
        if (reset) begin
            m_n = 0; m_inflight = 0; m_age = 0; m_valid = 0; m_wait = 0;
            m_a = 0; m_b = 0; m_op = 0; m_txd = 0;
            checkOutput("reset_outputs", {alu_a, alu_b, 2'b00, alu_op, tx_data},  32'h0);
            checkOutput("reset_flags",   {29'd0, busy, tx_start, err_tick}, 32'h0);
        end else begin
            timeout_now = 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
            timeout_now = (m_n > 0) && !m_inflight && !rx_done_tick && (m_wait == TCYC - 1);
`endif
            e_busy  = (m_n != 0) || m_inflight;
            e_start = m_inflight && (m_age == 2);
            e_err   = (m_inflight && rx_done_tick) || (m_inflight && m_age == 1 && !m_valid) || timeout_now;
            checkOutput("busy",     busy,     e_busy);
            checkOutput("tx_start", tx_start, e_start);
            checkOutput("err_tick", err_tick, e_err);
            checkOutput("tx_data",  tx_data,  m_txd);
            checkOutput("alu_a",    alu_a,    m_a);
            checkOutput("alu_b",    alu_b,    m_b);
            checkOutput("alu_op",   alu_op,   m_op);
            if (tx_start) tx_start_cnt++;
            if (err_tick) err_cnt++;

            if (m_inflight) begin
                if (m_age == 1) m_txd = m_valid ? alu_fn(m_a, m_b, m_op) : 8'hEE;
                if (m_age >= 3 && tx_done_tick) m_inflight = 0;
                else if (m_age < 3) m_age++;
            end else if (rx_done_tick) begin
                m_wait = 0;
                case (m_n)
                    0: begin m_a = rx_data; m_n = 1; end
                    1: begin m_b = rx_data; m_n = 2; end
                    default: begin
                        m_valid = op_legal(rx_data);
                        if (m_valid) m_op = rx_data[5:0];
                        m_inflight = 1; m_age = 1; m_n = 0;
                    end
                endcase
            end else if (timeout_now) begin
                m_n = 0; m_wait = 0;
            end else if (m_n > 0) begin
                m_wait++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Sends a 3-byte command and waits (bounded) for the reply to launch.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                                 input int gap_max, output logic [7:0] got, output int lat);
        bit found = 0;
        got = 8'h00;
        send_byte(a);
        idle($urandom_range(0, gap_max));
        send_byte(b);
        idle($urandom_range(0, gap_max));
        send_byte(op);
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_start) begin
                found = 1;
                got = tx_data;
                break;
            end
            lat++;
            @(posedge clk);
            #1;
        end
        if (found) begin
            @(posedge clk);
            #1;
        end else begin
            checkOutput("tx_start_wait_expired", 32'd0, 32'd1);
        end
    endtask

    task automatic finish_tx(input int delay);
        idle(delay);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_regs",  {alu_a, alu_b, 2'b00, alu_op, tx_data}, 32'h0);
        checkOutput("async_reset_flags", {29'd0, busy, tx_start, err_tick}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        logic [7:0] got;
        int         lat, s0, e0;
        #1 reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
        $display("[TB] directed commands");

        s0 = tx_start_cnt;
        applyStimulus(8'h05, 8'h03, 8'h20, 2, got, lat);
        checkOutput("add_latency", lat, 2);
        checkOutput("add_result", got, 8'h08);
        finish_tx(2);
        checkOutput("add_busy_after_done", busy, 1'b0);
        checkOutput("add_single_start", tx_start_cnt - s0, 1);

        applyStimulus(8'h03, 8'h05, 8'h22, 1, got, lat);
        checkOutput("sub_result", got, 8'hFE);
        finish_tx(1);
        applyStimulus(8'hF0, 8'h02, 8'h03, 1, got, lat);
        checkOutput("sra_result", got, 8'hFC);
        finish_tx(0);
        checkOutput("hold_operands", {alu_a, alu_b}, 16'hF002);

        e0 = err_cnt;
        applyStimulus(8'h01, 8'h02, 8'h3F, 0, got, lat);
        checkOutput("bad_op_reply", got, 8'hEE);
        finish_tx(1);
        applyStimulus(8'h01, 8'h02, 8'h60, 0, got, lat);
        checkOutput("upper_bits_reply", got, 8'hEE);
        finish_tx(1);
        checkOutput("bad_op_err_pulses", err_cnt - e0, 2);
        checkOutput("bad_op_keeps_op", alu_op, 6'h03);

        s0 = tx_start_cnt;
        e0 = err_cnt;
        applyStimulus(8'h07, 8'h01, 8'h20, 0, got, lat);
        send_byte(8'hAA);
        finish_tx(2);
        checkOutput("overrun_err_pulse", err_cnt - e0, 1);
        checkOutput("overrun_single_start", tx_start_cnt - s0, 1);
        applyStimulus(8'h02, 8'h02, 8'h24, 0, got, lat);
        checkOutput("after_overrun_and", got, 8'h02);
        finish_tx(1);

`ifdef ALU_CMD_TIMEOUT_EN
        s0 = tx_start_cnt;
        e0 = err_cnt;
        send_byte(8'h05);
        idle(20);
        checkOutput("timeout_err_pulse", err_cnt - e0, 1);
        checkOutput("timeout_idle", busy, 1'b0);
        checkOutput("timeout_no_start", tx_start_cnt - s0, 0);
        applyStimulus(8'h01, 8'h01, 8'h20, 0, got, lat);
        checkOutput("after_timeout_add", got, 8'h02);
        finish_tx(1);
`endif

        s0 = tx_start_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_reset();
        idle(5);
        checkOutput("reset_getop_no_start", tx_start_cnt - s0, 0);
        applyStimulus(8'h09, 8'h04, 8'h02, 0, got, lat);
        s0 = tx_start_cnt;
        pulse_reset();
        idle(5);
        checkOutput("reset_waittx_no_start", tx_start_cnt - s0, 0);
        applyStimulus(8'h0C, 8'h0A, 8'h26, 0, got, lat);
        checkOutput("after_reset_xor", got, 8'h06);
        finish_tx(1);

        $display("[TB] random commands");
        for (int i = 0; i < 60; i++) begin
            logic [7:0] a, b, op;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : legal_ops[$urandom_range(0, 7)];
            applyStimulus(a, b, op, 3, got, lat);
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom));
            finish_tx($urandom_range(0, 4));
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) finish_tx(0);
        end

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
